// File: rtl/uart_tx_mmap_if.sv
// CPU data-bus device port: the master drives address, strobes and write data;
// the device returns combinational read data.
interface mmap_dev;
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wd;
    logic [1:0]  wd_unit;
    logic [31:0] rd;

    modport master (output addr, re, we, wd, wd_unit, input rd);
    modport slave  (input addr, re, we, wd, wd_unit, output rd);
endinterface

// File: rtl/uart_tx_mmap.sv
// Memory-mapped 8N1 UART transmitter: a byte FIFO written over the data bus
// feeds a bit-timed shifter on tx. STATUS exposes full/empty/busy/overflow/count.
//
// state   | meaning
// --------+-----------------------------------------------------
// S_IDLE  | line high, waiting for a queued byte
// S_START | start bit (tx=0)
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit (tx=1); chains straight into S_START if queued
module uart_tx_mmap #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic   clk,
    input  logic   reset,
    output logic   tx,
    mmap_dev.slave iface
);
    localparam int TW = $clog2(CLK_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [TW-1:0] BIT_RELOAD = TW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] bit_tmr, bit_tmr_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          tx_nxt;
    logic          pop;
    logic          tmr_done;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          full, empty, busy;
    logic          sel_data, sel_status;
    logic          push_req, push, ovf_clr;

    // Upper address bits are decoded by the mmu; wd_unit and the upper write
    // data bits carry nothing this device needs.
    logic unused_bus;
    assign unused_bus = ^{iface.addr[31:3], iface.wd[31:8], iface.wd_unit};

    assign sel_data   = (iface.addr[2:0] == 3'h0);
    assign sel_status = (iface.addr[2:0] == 3'h4);
    assign full       = (count == DEPTH_CNT);
    assign empty      = (count == '0);
    assign busy       = (state != S_IDLE);
    assign tmr_done   = (bit_tmr == '0);

    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign push_req = iface.we && sel_data;
    assign push     = push_req && (!full || pop);
    assign ovf_clr  = iface.we && sel_status && iface.wd[3];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push_req && full && !pop) overflow <= 1'b1;
            else if (ovf_clr)             overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= iface.wd[7:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            bit_tmr <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            bit_tmr <= bit_tmr_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            tx      <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_tmr_nxt = bit_tmr;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        tx_nxt      = tx;
        pop         = 1'b0;
        if (state != S_IDLE && !tmr_done) bit_tmr_nxt = bit_tmr - 1'b1;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    state_nxt   = S_START;
                    shreg_nxt   = fifo_mem[rd_ptr];
                    bit_tmr_nxt = BIT_RELOAD;
                    tx_nxt      = 1'b0;
                end
            end
            S_START: begin
                if (tmr_done) begin
                    state_nxt   = S_DATA;
                    bit_tmr_nxt = BIT_RELOAD;
                    bit_cnt_nxt = '0;
                    tx_nxt      = shreg[0];
                end
            end
            S_DATA: begin
                if (tmr_done) begin
                    bit_tmr_nxt = BIT_RELOAD;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = S_STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        shreg_nxt   = {1'b0, shreg[7:1]};
                        tx_nxt      = shreg[1];
                    end
                end
            end
            S_STOP: begin
                if (tmr_done) begin
                    if (!empty) begin
                        pop         = 1'b1;
                        state_nxt   = S_START;
                        shreg_nxt   = fifo_mem[rd_ptr];
                        bit_tmr_nxt = BIT_RELOAD;
                        tx_nxt      = 1'b0;
                    end else begin
                        state_nxt = S_IDLE;
                        tx_nxt    = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        iface.rd = '0;
        if (iface.re && sel_status)
            iface.rd = {16'h0, 8'(count), 4'h0, overflow, busy, empty, full};
    end

endmodule
